// File: rtl/ramp_target_scheduler.sv
// Round-robin scheduler sharing one slow ramp datapath between N requesters.
// Define RAMP_TIMEOUT_EN to abort ramps that never arrive and flag them on Error.
module ramp_target_scheduler #(
    parameter int              Size          = 16,
    parameter int              N             = 4,
    parameter int              DwellCycles   = 1000,
    parameter logic [Size-1:0] IdleValue     = 16'b0001000000000000,
    parameter int              TimeoutCycles = 1_000_000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [N-1:0]      Req,
    input  logic [N*Size-1:0] Target,
    input  logic [Size-1:0]   Data,
    output logic [Size-1:0]   Dest,
    output logic [N-1:0]      Grant,
    output logic [N-1:0]      Done,
    output logic              Busy,
    output logic              Error
);
    // state   | meaning
    // IDLE    | arbitrating; Dest holds its last value
    // RAMP    | granted, waiting for Data to reach Dest
    // DWELL   | arrived, holding DwellCycles before completion
    // RELEASE | one-cycle Done pulse, pointer advance
    typedef enum logic [1:0] {IDLE, RAMP, DWELL, RELEASE} state_t;

    localparam int IW = $clog2(N);
    localparam int CW = (DwellCycles > 1) ? $clog2(DwellCycles) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = (DwellCycles > 0) ? CW'(DwellCycles - 1) : '0;
    localparam logic [N-1:0]  ONE        = N'(1);

    if (N < 2 || N > 8 || DwellCycles < 0 || TimeoutCycles < 1) begin : g_param_check
        $error("ramp_target_scheduler: parameter out of range");
    end

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;
    logic [CW-1:0]   dcnt_q, dcnt_d;
    logic [Size-1:0] dest_d;
    logic [N-1:0]    grant_d, done_d;
    logic            busy_d, error_d;
    logic            found;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   nxt_ptr;
`ifdef RAMP_TIMEOUT_EN
    logic [31:0]     tcnt_q, tcnt_d;
`endif

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && Req[(int'(ptr_q) + k) % N]) begin
                found  = 1'b1;
                winner = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    assign nxt_ptr = IW'((int'(win_q) + 1) % N);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        dcnt_d  = dcnt_q;
        dest_d  = Dest;
        grant_d = Grant;
        done_d  = '0;
        busy_d  = Busy;
        error_d = 1'b0;
`ifdef RAMP_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = winner;
                    grant_d = ONE << winner;
                    dest_d  = Target[int'(winner)*Size +: Size];
                    busy_d  = 1'b1;
                    state_d = RAMP;
`ifdef RAMP_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            RAMP: begin
                if (!Req[win_q]) begin
                    // Freeze the ramp where it stands.
                    dest_d  = Data;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else if (Data == Dest) begin
                    if (DwellCycles == 0) begin
                        grant_d = '0;
                        busy_d  = 1'b0;
                        done_d  = ONE << win_q;
                        state_d = RELEASE;
                    end else begin
                        dcnt_d  = DWELL_LOAD;
                        state_d = DWELL;
                    end
`ifdef RAMP_TIMEOUT_EN
                end else if (tcnt_q == 32'(TimeoutCycles - 1)) begin
                    dest_d  = Data;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else begin
                    tcnt_d  = tcnt_q + 32'd1;
`endif
                end
            end
            DWELL: begin
                if (!Req[win_q]) begin
                    dest_d  = Data;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end else if (dcnt_q == '0) begin
                    grant_d = '0;
                    busy_d  = 1'b0;
                    done_d  = ONE << win_q;
                    state_d = RELEASE;
                end else begin
                    dcnt_d  = dcnt_q - CW'(1);
                end
            end
            RELEASE: begin
                ptr_d   = nxt_ptr;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            dcnt_q  <= '0;
            Dest    <= IdleValue;
            Grant   <= '0;
            Done    <= '0;
            Busy    <= 1'b0;
            Error   <= 1'b0;
`ifdef RAMP_TIMEOUT_EN
            tcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            dcnt_q  <= dcnt_d;
            Dest    <= dest_d;
            Grant   <= grant_d;
            Done    <= done_d;
            Busy    <= busy_d;
            Error   <= error_d;
`ifdef RAMP_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
`endif
        end
    end

endmodule
